// File: rtl/gpio_rd_pkg.sv
// Shared constants, address map and FSM encoding for the GPIO stream reader.
// CPU word layout: [31] strobe, [23:16] address, [15:0] write data.
package gpio_rd_pkg;

    localparam int STROBE_BIT    = 31;
    localparam int ADDR_HI       = 23;
    localparam int ADDR_LO       = 16;
    localparam int WDATA_HI      = 15;
    localparam int WDATA_LO      = 0;
    localparam int CLEAR_ALL_BIT = 15;

    localparam logic [7:0] STREAM_BASE = 8'h00;
    localparam logic [7:0] STAT_BASE   = 8'h40;
    localparam logic [7:0] CHSTAT_BASE = 8'h80;
    localparam logic [7:0] CTRL_ADDR   = 8'hF0;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

    // Each base sits on a 64-entry boundary, so the top two address bits pick the region.
    typedef enum logic [1:0] {
        REGION_STREAM = 2'b00,
        REGION_STAT   = 2'b01,
        REGION_CHSTAT = 2'b10,
        REGION_MISC   = 2'b11
    } region_e;

    function automatic region_e region_of(input logic [7:0] addr);
        return region_e'(addr[7:6]);
    endfunction

endpackage

// File: rtl/gpio_strobe_sync.sv
// Two-flop synchronizer and rising-edge detector for the CPU strobe.
// An edge is only reported after a genuine synchronized low has been seen since reset.
module gpio_strobe_sync (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic level,
    output logic rise
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic [1:0] warm_q;
    logic       armed_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            warm_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            meta_q <= strobe;
            sync_q <= meta_q;
            prev_q <= sync_q;
            warm_q <= {warm_q[0], 1'b1};
            // sync_q only reflects the pin once warm_q[1] is set; before that it is the reset value.
            if (warm_q[1] && !sync_q)
                armed_q <= 1'b1;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q & armed_q;

endmodule

// File: rtl/gpio_stream_reader.sv
// CPU-side GPIO readback of AXI-stream channels and status words, 16 bits per strobe.
// Each capture decodes one address, updates only the addressed channel, and latches the reply.
module gpio_stream_reader
    import gpio_rd_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 128,
    parameter int NUM_STAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              gpio_in,
    output logic [15:0]              gpio_out,
    output logic                     gpio_ack,
    output logic                     gpio_valid,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_valid,
    output logic [NUM_CH-1:0]        s_ready,
    input  logic [NUM_STAT*32-1:0]   stat_in
);

    localparam int BEATS  = DATA_W / 16;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e state_q, state_d;

    logic strobe_level;
    logic strobe_rise;
    logic capture;

    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        unused_bits;

    logic [BEAT_W-1:0] beat_q [NUM_CH];
    logic [NUM_CH-1:0] underflow_q;

    logic [15:0]       rd_data;
    logic              rd_valid;
    logic [NUM_CH-1:0] adv;
    logic [NUM_CH-1:0] uf_set;
    logic [NUM_CH-1:0] clr;
    logic [DATA_W-1:0] chan_word;
    logic [31:0]       stat_word;

    gpio_strobe_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .strobe (gpio_in[STROBE_BIT]),
        .level  (strobe_level),
        .rise   (strobe_rise)
    );

    assign addr        = gpio_in[ADDR_HI:ADDR_LO];
    assign wdata       = gpio_in[WDATA_HI:WDATA_LO];
    assign unused_bits = ^{gpio_in[30:24], wdata};
    assign capture     = (state_q == IDLE) && strobe_rise;
    assign gpio_ack    = (state_q == HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: every signal written here is given a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (strobe_rise)   state_d = HOLD;
            HOLD:    if (!strobe_level) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address decode; an index past the configured channel/stat count falls through to 0, valid=1.
    always_comb begin
        rd_data   = '0;
        rd_valid  = 1'b1;
        adv       = '0;
        uf_set    = '0;
        clr       = '0;
        chan_word = '0;
        stat_word = '0;
        case (region_of(addr))
            REGION_STREAM: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (addr[5:0] == 6'(k)) begin
                        if (s_valid[k]) begin
                            chan_word = s_data[k*DATA_W +: DATA_W];
                            rd_data   = 16'(chan_word >> (32'(beat_q[k]) * 16));
                            adv[k]    = 1'b1;
                        end else begin
                            rd_valid  = 1'b0;
                            uf_set[k] = 1'b1;
                        end
                    end
                end
            end
            REGION_STAT: begin
                for (int j = 0; j < NUM_STAT; j++) begin
                    if (addr[5:1] == 5'(j)) begin
                        stat_word = stat_in[j*32 +: 32];
                        rd_data   = addr[0] ? stat_word[31:16] : stat_word[15:0];
                    end
                end
            end
            REGION_CHSTAT: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (addr[5:0] == 6'(k))
                        rd_data = {underflow_q[k], s_valid[k], 6'b0, 8'(beat_q[k])};
                end
            end
            default: begin
                if (addr == CTRL_ADDR)
                    clr = wdata[CLEAR_ALL_BIT] ? {NUM_CH{1'b1}} : wdata[NUM_CH-1:0];
            end
        endcase
    end

    // NOTE: the beat array is a handful of flops, so it is reset explicitly rather than left to a clear sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out    <= '0;
            gpio_valid  <= 1'b0;
            s_ready     <= '0;
            underflow_q <= '0;
            for (int k = 0; k < NUM_CH; k++)
                beat_q[k] <= '0;
        end else begin
            s_ready <= '0;
            if (capture) begin
                gpio_out   <= rd_data;
                gpio_valid <= rd_valid;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (clr[k]) begin
                        beat_q[k]      <= '0;
                        underflow_q[k] <= 1'b0;
                    end else if (adv[k]) begin
                        if (beat_q[k] == LAST_BEAT) begin
                            beat_q[k]  <= '0;
                            s_ready[k] <= 1'b1;
                        end else begin
                            beat_q[k] <= beat_q[k] + 1'b1;
                        end
                    end
                    if (uf_set[k])
                        underflow_q[k] <= 1'b1;
                end
            end
        end
    end

endmodule
